// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter_pkg
// Description : Shared types for the GPR write-side arbiter and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_write_arbiter_pkg;

  localparam int c_WORD_W = 32;
  localparam int c_CREG_W = 5;

  typedef logic [c_WORD_W-1:0] word_t;
  typedef logic [c_CREG_W-1:0] creg_addr_t;

  typedef struct packed {
    creg_addr_t wa;
    word_t      wd;
  } wb_req_t;

  localparam creg_addr_t c_ZERO_REG = '0;

  // r0 is hardwired, so writes to it and hazards on it never exist.
  function automatic logic is_live_reg(input creg_addr_t a);
    return a != c_ZERO_REG;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter_if
// Description : Writeback sources, regfile write port and hazard query bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
);

  logic                        pipe_valid;
  creg_addr_t                  pipe_wa;
  word_t                       pipe_wd;
  logic                        pipe_stall;
  logic                        mdu_valid;
  logic                        mdu_ready;
  creg_addr_t                  mdu_wa;
  word_t                       mdu_wd;
  creg_addr_t                  wa3;
  word_t                       wd3;
  logic                        write_enable;
  creg_addr_t                  qry_ra1;
  creg_addr_t                  qry_ra2;
  logic                        pend1;
  logic                        pend2;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  modport master (
    output pipe_valid, pipe_wa, pipe_wd, mdu_valid, mdu_wa, mdu_wd,
           qry_ra1, qry_ra2,
    input  pipe_stall, mdu_ready, wa3, wd3, write_enable, pend1, pend2,
           fifo_count
  );

  modport slave (
    input  pipe_valid, pipe_wa, pipe_wd, mdu_valid, mdu_wa, mdu_wd,
           qry_ra1, qry_ra2,
    output pipe_stall, mdu_ready, wa3, wd3, write_enable, pend1, pend2,
           fifo_count
  );

endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter_wb_fifo
// Description : Multi-cycle result FIFO exposing per-entry valid and address.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter_wb_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
)(
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              i_push,
  input  wb_req_t                           i_push_data,
  input  logic                              i_pop,
  output wb_req_t                           o_head,
  output logic                              o_full,
  output logic                              o_empty,
  output logic [$clog2(FIFO_DEPTH):0]       o_count,
  output logic [FIFO_DEPTH-1:0]             o_entry_valid,
  output creg_addr_t [FIFO_DEPTH-1:0]       o_entry_wa
);

  localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(FIFO_DEPTH);

  wb_req_t                 r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [c_CNT_W-1:0]      r_count;
  logic [FIFO_DEPTH-1:0]   r_valid;
  logic [FIFO_DEPTH-1:0]   w_valid_next;
  logic                    w_push;
  logic                    w_pop;

  assign o_full  = (r_count == c_FULL);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_comb begin
    w_valid_next = r_valid;
    if (w_pop)  w_valid_next[r_rd_ptr] = 1'b0;
    if (w_push) w_valid_next[r_wr_ptr] = 1'b1;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_valid <= w_valid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head        = r_mem[r_rd_ptr];
  assign o_count       = r_count;
  assign o_entry_valid = r_valid;

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry_wa
    assign o_entry_wa[gi] = r_mem[gi].wa;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Merges pipeline and multi-cycle writeback onto one GPR port.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
)(
  input  logic                    clk,
  input  logic                    resetn,
  regfile_write_arbiter_if.slave  bus
);

  localparam int                    c_CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int                    c_STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

  wb_req_t                     w_head;
  logic                        w_full;
  logic                        w_empty;
  logic [c_CNT_W-1:0]          w_count;
  logic [FIFO_DEPTH-1:0]       w_entry_valid;
  creg_addr_t [FIFO_DEPTH-1:0] w_entry_wa;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_pipe_win;
  logic                        w_starve_inc;
  logic [c_STARVE_W-1:0]       w_starve_nxt;
  logic [FIFO_DEPTH-1:0]       w_hit1;
  logic [FIFO_DEPTH-1:0]       w_hit2;

  logic                        r_pipe_stall;
  logic                        r_we;
  creg_addr_t                  r_wa3;
  word_t                       r_wd3;
  logic [c_STARVE_W-1:0]       r_starve;

  // Writes to r0 are accepted on the handshake but never enqueued.
  assign w_push       = bus.mdu_valid && !w_full && is_live_reg(bus.mdu_wa);
  assign w_pipe_win   = !r_pipe_stall && bus.pipe_valid && is_live_reg(bus.pipe_wa);
  assign w_pop        = !w_empty && !w_pipe_win;
  assign w_starve_inc = w_pipe_win && !w_empty;
  assign w_starve_nxt = r_starve + c_STARVE_W'(1);

  regfile_write_arbiter_wb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_wb_fifo (
    .clk           (clk),
    .resetn        (resetn),
    .i_push        (w_push),
    .i_push_data   ({bus.mdu_wa, bus.mdu_wd}),
    .i_pop         (w_pop),
    .o_head        (w_head),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_count       (w_count),
    .o_entry_valid (w_entry_valid),
    .o_entry_wa    (w_entry_wa)
  );

  // The stall cycle pops the head, which clears the counter, so it never
  // exceeds STARVE_LIMIT.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_starve     <= '0;
      r_pipe_stall <= 1'b0;
    end else begin
      if (w_pop || w_empty)  r_starve <= '0;
      else if (w_starve_inc) r_starve <= w_starve_nxt;
      r_pipe_stall <= w_starve_inc && (w_starve_nxt == c_STARVE_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_we  <= 1'b0;
      r_wa3 <= '0;
      r_wd3 <= '0;
    end else if (w_pipe_win) begin
      r_we  <= 1'b1;
      r_wa3 <= bus.pipe_wa;
      r_wd3 <= bus.pipe_wd;
    end else if (w_pop) begin
      r_we  <= 1'b1;
      r_wa3 <= w_head.wa;
      r_wd3 <= w_head.wd;
    end else begin
      r_we  <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_match
    assign w_hit1[gi] = w_entry_valid[gi] && (w_entry_wa[gi] == bus.qry_ra1);
    assign w_hit2[gi] = w_entry_valid[gi] && (w_entry_wa[gi] == bus.qry_ra2);
  end

  // The regfile reads pre-write state, so the output stage is still pending.
  assign bus.pend1 = is_live_reg(bus.qry_ra1) &&
                     ((|w_hit1) || (r_we && (r_wa3 == bus.qry_ra1)));
  assign bus.pend2 = is_live_reg(bus.qry_ra2) &&
                     ((|w_hit2) || (r_we && (r_wa3 == bus.qry_ra2)));

  assign bus.pipe_stall   = r_pipe_stall;
  assign bus.mdu_ready    = !w_full;
  assign bus.wa3          = r_wa3;
  assign bus.wd3          = r_wd3;
  assign bus.write_enable = r_we;
  assign bus.fifo_count   = w_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Scoreboard bench: write-order reference model vs. the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

  regfile_write_arbiter #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: queued results, output stage, starvation bookkeeping.
  wb_req_t    m_q[$];
  wb_req_t    exp_q[$];
  int         m_starve;
  bit         m_stall;
  bit         m_we;
  creg_addr_t m_wa3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_starve = 0;
    m_stall  = 0;
    m_we     = 0;
    m_wa3    = '0;
  endtask

  function automatic bit m_pending(input creg_addr_t r);
    if (r == 0) return 0;
    if (m_we && m_wa3 == r) return 1;
    foreach (m_q[i]) if (m_q[i].wa == r) return 1;
    return 0;
  endfunction

  function automatic creg_addr_t pick(input creg_addr_t avoid);
    creg_addr_t r;
    for (int t = 0; t < 8; t++) begin
      r = creg_addr_t'($urandom_range(1, 31));
      if (r != avoid && !m_pending(r)) return r;
    end
    return '0;
  endfunction

  // Called just after a negedge: check present outputs, drive one cycle of
  // stimulus, advance the model to the next edge, wait for the next negedge.
  task automatic step(input logic pv, input creg_addr_t pwa, input word_t pwd,
                      input logic mv, input creg_addr_t mwa, input word_t mwd,
                      input creg_addr_t q1, input creg_addr_t q2);
    bit      pop, rdy, stall_nxt;
    wb_req_t head;
    check("we",    32'(bus.write_enable), 32'(m_we));
    check("count", 32'(bus.fifo_count),   32'(m_q.size()));
    check("ready", 32'(bus.mdu_ready),    32'(m_q.size() < DEPTH));
    check("stall", 32'(bus.pipe_stall),   32'(m_stall));
    bus.qry_ra1 = q1;
    bus.qry_ra2 = q2;
    #1;
    check("pend1", 32'(bus.pend1), 32'(m_pending(q1)));
    check("pend2", 32'(bus.pend2), 32'(m_pending(q2)));
    bus.pipe_valid = pv;  bus.pipe_wa = pwa;  bus.pipe_wd = pwd;
    bus.mdu_valid  = mv;  bus.mdu_wa  = mwa;  bus.mdu_wd  = mwd;

    rdy       = m_q.size() < DEPTH;
    pop       = 0;
    stall_nxt = 0;
    if (m_q.size() == 0) m_starve = 0;
    if (m_stall) begin
      pop = 1;
    end else if (pv && pwa != 0) begin
      exp_q.push_back(wb_req_t'{wa: pwa, wd: pwd});
      m_we  = 1;
      m_wa3 = pwa;
      if (m_q.size() != 0) begin
        m_starve++;
        if (m_starve == LIMIT) stall_nxt = 1;
      end
    end else if (m_q.size() != 0) begin
      pop = 1;
    end else begin
      m_we = 0;
    end
    if (pop) begin
      head = m_q.pop_front();
      exp_q.push_back(head);
      m_we     = 1;
      m_wa3    = head.wa;
      m_starve = 0;
    end
    if (mv && rdy && mwa != 0) m_q.push_back(wb_req_t'{wa: mwa, wd: mwd});
    m_stall = stall_nxt;
    @(negedge clk);
  endtask

  task automatic idle(input creg_addr_t q);
    step(1'b0, '0, '0, 1'b0, '0, '0, q, '0);
  endtask

  task automatic pend_chk(input string name, input creg_addr_t q, input logic exp);
    bus.qry_ra1 = q;
    #1;
    check(name, 32'(bus.pend1), 32'(exp));
  endtask

  // Monitor: every regfile write must be the next one the model predicted.
  always @(negedge clk) begin
    wb_req_t e;
    if (bus.write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got write wa3=%0d wd3=0x%0h, expected none (t=%0t)",
                 bus.wa3, bus.wd3, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_wa3", 32'(bus.wa3), 32'(e.wa));
        check("sb_wd3", bus.wd3, e.wd);
      end
    end
  end

  initial begin
    creg_addr_t pwa, mwa, q1, next_m;
    word_t      pwd, mwd;
    logic       pv, mv, hold, hold_next;
    int         stall_at;

    bus.pipe_valid = 0; bus.pipe_wa = '0; bus.pipe_wd = '0;
    bus.mdu_valid  = 0; bus.mdu_wa  = '0; bus.mdu_wd  = '0;
    bus.qry_ra1    = '0; bus.qry_ra2 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_we",    32'(bus.write_enable), 32'd0);
    check("rst_wa3",   32'(bus.wa3),          32'd0);
    check("rst_wd3",   bus.wd3,               32'd0);
    check("rst_stall", 32'(bus.pipe_stall),   32'd0);
    check("rst_count", 32'(bus.fifo_count),   32'd0);
    check("rst_ready", 32'(bus.mdu_ready),    32'd1);
    resetn = 1'b1;

    // Single pipeline writeback, one-cycle latency.
    step(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, 5'd5, '0);
    check("t1_we",  32'(bus.write_enable), 32'd1);
    check("t1_wa3", 32'(bus.wa3),          32'd5);
    check("t1_wd3", bus.wd3,               32'h1234);
    idle(5'd5);
    check("t1_we_off", 32'(bus.write_enable), 32'd0);

    // Multi-cycle result through the FIFO, two-cycle latency.
    step(1'b0, '0, '0, 1'b1, 5'd7, 32'hCAFE, 5'd7, '0);
    check("t2_count", 32'(bus.fifo_count), 32'd1);
    pend_chk("t2_pend_q", 5'd7, 1'b1);
    idle(5'd7);
    check("t2_we",    32'(bus.write_enable), 32'd1);
    check("t2_wa3",   32'(bus.wa3),          32'd7);
    check("t2_wd3",   bus.wd3,               32'hCAFE);
    check("t2_count0", 32'(bus.fifo_count),  32'd0);
    idle(5'd7);
    check("t2_we_off", 32'(bus.write_enable), 32'd0);
    pend_chk("t2_pend_done", 5'd7, 1'b0);

    // Continuous pipeline traffic starves the FIFO until the forced stall.
    stall_at = -1;
    next_m   = 5'd10;
    hold     = 0;
    pwa      = '0;
    pwd      = '0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) begin
        check("t3_count_full", 32'(bus.fifo_count), 32'd4);
        check("t3_ready_full", 32'(bus.mdu_ready),  32'd0);
      end
      if (bus.pipe_stall === 1'b1 && stall_at < 0) stall_at = i;
      hold_next = m_stall;
      if (!hold) begin
        pwa = creg_addr_t'(16 + (i % 8));
        pwd = 32'(i);
      end
      mv = (next_m <= 5'd14);
      mwa = next_m;
      if (mv && m_q.size() < DEPTH) next_m = next_m + 5'd1;
      step(1'b1, pwa, pwd, mv, mwa, 32'h100 + 32'(mwa), creg_addr_t'(10 + (i % 5)), pwa);
      if (i == 9) begin
        check("t3_head_wa3", 32'(bus.wa3), 32'd10);
        check("t3_head_wd3", bus.wd3,      32'h10A);
      end
      hold = hold_next;
    end
    check("t3_stall_cycle", 32'(stall_at), 32'd9);
    repeat (8) idle('0);

    // r0 on both sources: no write, nothing queued, never pending.
    step(1'b1, '0, 32'hDEAD, 1'b1, '0, 32'hBEEF, '0, '0);
    check("t4_we",    32'(bus.write_enable), 32'd0);
    check("t4_count", 32'(bus.fifo_count),   32'd0);
    pend_chk("t4_pend0", '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 5'd9, 32'h99, '0, '0);
    step(1'b1, '0, 32'h5555, 1'b0, '0, '0, '0, '0);
    check("t4_slot_wa3", 32'(bus.wa3), 32'd9);
    idle('0);

    // Reset while full drops every queued entry.
    for (int i = 0; i < 4; i++)
      step(1'b1, creg_addr_t'(20 + i), 32'(i), 1'b1, creg_addr_t'(1 + i), 32'h200 + 32'(i), '0, '0);
    check("t5_full", 32'(bus.mdu_ready), 32'd0);
    resetn = 1'b0;
    bus.pipe_valid = 1; bus.pipe_wa = 5'd25;
    bus.mdu_valid  = 1; bus.mdu_wa  = 5'd6;
    @(negedge clk);
    model_reset();
    resetn = 1'b1;
    check("t5_count", 32'(bus.fifo_count),   32'd0);
    check("t5_we",    32'(bus.write_enable), 32'd0);
    check("t5_ready", 32'(bus.mdu_ready),    32'd1);
    repeat (4) idle(5'd1);

    // Random traffic honouring the no-write-to-pending-reg rule.
    hold = 0; pv = 0; pwa = '0; pwd = '0;
    for (int i = 0; i < 400; i++) begin
      hold_next = m_stall;
      if (!hold) begin
        pv  = ($urandom_range(0, 3) != 0);
        pwa = ($urandom_range(0, 15) == 0) ? creg_addr_t'(0) : pick('0);
        pwd = $urandom;
      end
      mv  = ($urandom_range(0, 1) == 1);
      mwa = ($urandom_range(0, 15) == 0) ? creg_addr_t'(0) : pick(pv ? pwa : creg_addr_t'(0));
      mwd = $urandom;
      q1  = creg_addr_t'($urandom_range(0, 31));
      step(pv, pwa, pwd, mv, mwa, mwd, q1, pwa);
      hold = hold_next;
    end
    repeat (12) idle('0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
